// File: rtl/imem_fetch_resp.sv
// imem_fetch_resp
//   Memory-side responder for the instruction-fetch address stream. It takes
//   one fetch request at a time from the PC stage and validates it. A legal
//   request is read from a synchronous SRAM with a fixed read latency, and the
//   word is returned to decode under a valid/ready handshake. An illegal
//   request (overflow or misaligned) raises a one-cycle error pulse and halts
//   the block until reset.
//
// Parameters
//   ADDR_WIDTH : PC byte-address width
//   DATA_WIDTH : instruction width
//   MEM_ADDR_W : SRAM word-address width
//   MEM_LAT    : SRAM read latency (>=1), enable cycle to data-valid cycle
//
// Ports
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_req_valid/i_req_addr/i_req_overflow/o_req_ready   fetch request
//   o_mem_cen/o_mem_addr/i_mem_rdata   SRAM read port
//   o_inst_valid/o_inst/i_inst_ready   instruction handshake to decode
//   o_err_valid/o_err_code/o_halted    error pulse, code, sticky halt
module imem_fetch_resp #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_ADDR_W = 10,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic                  i_req_overflow,
    output logic                  o_req_ready,
    output logic                  o_mem_cen,
    output logic [MEM_ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_inst_valid,
    output logic [DATA_WIDTH-1:0] o_inst,
    input  logic                  i_inst_ready,
    output logic                  o_err_valid,
    output logic [1:0]            o_err_code,
    output logic                  o_halted
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] lat_cnt;
    logic             addr_hi_nz;
    logic             addr_misaligned;

    // Any byte-address bit above the SRAM window means the PC left the legal space.
    always_comb begin
        addr_hi_nz      = |i_req_addr[ADDR_WIDTH-1:MEM_ADDR_W+2];
        addr_misaligned = |i_req_addr[1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            lat_cnt      <= '0;
            o_req_ready  <= 1'b1;
            o_mem_cen    <= 1'b0;
            o_mem_addr   <= '0;
            o_inst       <= '0;
            o_inst_valid <= 1'b0;
            o_err_valid  <= 1'b0;
            o_err_code   <= 2'd0;
            o_halted     <= 1'b0;
        end else begin
            // Both are single-cycle pulses; only the transitions below raise them.
            o_mem_cen   <= 1'b0;
            o_err_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        o_mem_addr  <= i_req_addr[MEM_ADDR_W+1:2];
                        o_req_ready <= 1'b0;
                        if (i_req_overflow || addr_hi_nz) begin
                            state       <= S_ERR;
                            o_err_valid <= 1'b1;
                            o_err_code  <= 2'd1;
                            o_halted    <= 1'b1;
                        end else if (addr_misaligned) begin
                            state       <= S_ERR;
                            o_err_valid <= 1'b1;
                            o_err_code  <= 2'd2;
                            o_halted    <= 1'b1;
                        end else begin
                            // Enable is registered so it is high during the READ cycle.
                            state     <= S_READ;
                            o_mem_cen <= 1'b1;
                        end
                    end
                end

                S_READ: begin
                    lat_cnt <= CNT_LOAD;
                    state   <= S_WAIT;
                end

                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        o_inst       <= i_mem_rdata;
                        o_inst_valid <= 1'b1;
                        state        <= S_HOLD;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end

                S_HOLD: begin
                    if (i_inst_ready) begin
                        o_inst_valid <= 1'b0;
                        o_req_ready  <= 1'b1;
                        state        <= S_IDLE;
                    end
                end

                S_ERR: begin
                    state <= S_ERR;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_resp.sv
// tb_imem_fetch_resp
//   Directed bench for imem_fetch_resp. Two instances share the clock:
//   u_lat1 (MEM_LAT=1) and u_lat3 (MEM_LAT=3). Each instance has its own
//   SRAM model. The model returns the addressed word only in the data-valid
//   cycle and a poison value in every other cycle. Inputs are driven and
//   outputs are sampled on the falling edge.
module tb_imem_fetch_resp;

    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        if (a == 10'd4)        return 32'hDEAD_BEEF;
        else if (a == 10'h3FF) return 32'h1234_5678;
        else                   return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    // ---------------- instance with MEM_LAT=1 ----------------
    logic        rst0 = 1'b1, req_valid0 = 1'b0, req_ovf0 = 1'b0, inst_ready0 = 1'b0;
    logic [31:0] req_addr0 = '0;
    logic        req_ready0, cen0, inst_valid0, err_valid0, halted0;
    logic [9:0]  maddr0;
    logic [31:0] rdata0, inst0;
    logic [1:0]  err_code0;
    logic        m0_v = 1'b0;
    logic [9:0]  m0_a = '0;

    always @(posedge clk) begin
        m0_v <= cen0;
        m0_a <= maddr0;
    end
    assign rdata0 = m0_v ? mem_word(m0_a) : POISON;

    imem_fetch_resp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_W(10), .MEM_LAT(1)) u_lat1 (
        .i_clk(clk), .i_rst(rst0),
        .i_req_valid(req_valid0), .i_req_addr(req_addr0), .i_req_overflow(req_ovf0),
        .o_req_ready(req_ready0),
        .o_mem_cen(cen0), .o_mem_addr(maddr0), .i_mem_rdata(rdata0),
        .o_inst_valid(inst_valid0), .o_inst(inst0), .i_inst_ready(inst_ready0),
        .o_err_valid(err_valid0), .o_err_code(err_code0), .o_halted(halted0)
    );

    // ---------------- instance with MEM_LAT=3 ----------------
    logic        rst1 = 1'b1, req_valid1 = 1'b0, req_ovf1 = 1'b0, inst_ready1 = 1'b0;
    logic [31:0] req_addr1 = '0;
    logic        req_ready1, cen1, inst_valid1, err_valid1, halted1;
    logic [9:0]  maddr1;
    logic [31:0] rdata1, inst1;
    logic [1:0]  err_code1;
    logic [2:0]  m1_v = '0;
    logic [9:0]  m1_a0 = '0, m1_a1 = '0, m1_a2 = '0;

    always @(posedge clk) begin
        m1_v  <= {m1_v[1:0], cen1};
        m1_a0 <= maddr1;
        m1_a1 <= m1_a0;
        m1_a2 <= m1_a1;
    end
    assign rdata1 = m1_v[2] ? mem_word(m1_a2) : POISON;

    imem_fetch_resp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_W(10), .MEM_LAT(3)) u_lat3 (
        .i_clk(clk), .i_rst(rst1),
        .i_req_valid(req_valid1), .i_req_addr(req_addr1), .i_req_overflow(req_ovf1),
        .o_req_ready(req_ready1),
        .o_mem_cen(cen1), .o_mem_addr(maddr1), .i_mem_rdata(rdata1),
        .o_inst_valid(inst_valid1), .o_inst(inst1), .i_inst_ready(inst_ready1),
        .o_err_valid(err_valid1), .o_err_code(err_code1), .o_halted(halted1)
    );

    task automatic reset0();
        rst0 = 1'b1; req_valid0 = 1'b0; req_ovf0 = 1'b0;
        step();
        check("rst0_ready",  32'(req_ready0), 32'd1);
        check("rst0_halted", 32'(halted0),    32'd0);
        check("rst0_code",   32'(err_code0),  32'd0);
        rst0 = 1'b0;
        step();
    endtask

    initial begin
        step();
        step();
        // Reset values, u_lat1
        check("rst_ready",   32'(req_ready0),  32'd1);
        check("rst_cen",     32'(cen0),        32'd0);
        check("rst_maddr",   32'(maddr0),      32'd0);
        check("rst_inst",    inst0,            32'd0);
        check("rst_ivalid",  32'(inst_valid0), 32'd0);
        check("rst_errv",    32'(err_valid0),  32'd0);
        check("rst_code",    32'(err_code0),   32'd0);
        check("rst_halted",  32'(halted0),     32'd0);
        rst0 = 1'b0;
        step();

        // Fetch 0x10 with back-pressure in HOLD
        req_valid0 = 1'b1; req_addr0 = 32'h0000_0010;
        step();                                          // T+1
        check("f1_cen",    32'(cen0),        32'd1);
        check("f1_maddr",  32'(maddr0),      32'd4);
        check("f1_ready",  32'(req_ready0),  32'd0);
        check("f1_iv_t1",  32'(inst_valid0), 32'd0);
        req_valid0 = 1'b0;
        step();                                          // T+2
        check("f1_cen_t2", 32'(cen0),        32'd0);
        check("f1_iv_t2",  32'(inst_valid0), 32'd0);
        step();                                          // T+3
        check("f1_iv_t3",  32'(inst_valid0), 32'd1);
        check("f1_inst",   inst0,            32'hDEAD_BEEF);
        req_valid0 = 1'b1; req_addr0 = 32'h0000_0020;   // must be ignored
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_iv",    32'(inst_valid0), 32'd1);
            check("bp_inst",  inst0,            32'hDEAD_BEEF);
            check("bp_ready", 32'(req_ready0),  32'd0);
            check("bp_cen",   32'(cen0),        32'd0);
        end
        req_valid0 = 1'b0; inst_ready0 = 1'b1;
        step();
        check("hs_iv",     32'(inst_valid0), 32'd0);
        check("hs_ready",  32'(req_ready0),  32'd1);
        step();
        check("noq_cen",   32'(cen0),        32'd0);
        check("noq_ready", 32'(req_ready0),  32'd1);

        // Fetch 0x3FC with decode already ready: HOLD lasts one cycle
        req_valid0 = 1'b1; req_addr0 = 32'h0000_03FC;
        step();
        check("f2_cen",    32'(cen0),   32'd1);
        check("f2_maddr",  32'(maddr0), 32'h0FF);
        req_valid0 = 1'b0;
        step();
        check("f2_iv_t2",  32'(inst_valid0), 32'd0);
        step();
        check("f2_iv_t3",  32'(inst_valid0), 32'd1);
        check("f2_inst",   inst0,            32'hC0DE_00FF);
        check("f2_ready",  32'(req_ready0),  32'd0);
        step();
        check("f2_iv_t4",  32'(inst_valid0), 32'd0);
        check("f2_rdy_t4", 32'(req_ready0),  32'd1);
        inst_ready0 = 1'b0;

        // Out-of-range address, overflow flag low -> code 1, then locked
        req_valid0 = 1'b1; req_addr0 = 32'h0000_1000; req_ovf0 = 1'b0;
        step();
        check("ovr_errv",   32'(err_valid0), 32'd1);
        check("ovr_code",   32'(err_code0),  32'd1);
        check("ovr_halted", 32'(halted0),    32'd1);
        check("ovr_ready",  32'(req_ready0), 32'd0);
        check("ovr_cen",    32'(cen0),       32'd0);
        req_addr0 = 32'h0000_0010;                       // legal, must be ignored
        for (int i = 0; i < 4; i++) begin
            step();
            check("lock_errv",   32'(err_valid0), 32'd0);
            check("lock_code",   32'(err_code0),  32'd1);
            check("lock_halted", 32'(halted0),    32'd1);
            check("lock_ready",  32'(req_ready0), 32'd0);
            check("lock_cen",    32'(cen0),       32'd0);
        end
        reset0();

        // Misaligned -> code 2
        req_valid0 = 1'b1; req_addr0 = 32'h0000_0006;
        step();
        check("mis_errv", 32'(err_valid0), 32'd1);
        check("mis_code", 32'(err_code0),  32'd2);
        check("mis_cen",  32'(cen0),       32'd0);
        req_valid0 = 1'b0;
        step();
        check("mis_errv2", 32'(err_valid0), 32'd0);
        check("mis_code2", 32'(err_code0),  32'd2);
        check("mis_cen2",  32'(cen0),       32'd0);
        reset0();

        // Overflow and misaligned together -> overflow wins
        req_valid0 = 1'b1; req_addr0 = 32'h0000_2002; req_ovf0 = 1'b1;
        step();
        check("pri_errv", 32'(err_valid0), 32'd1);
        check("pri_code", 32'(err_code0),  32'd1);
        check("pri_cen",  32'(cen0),       32'd0);
        req_valid0 = 1'b0; req_ovf0 = 1'b0;

        // MEM_LAT=3 instance: top word of the space
        rst1 = 1'b0;
        step();
        check("l3_rst_ready", 32'(req_ready1), 32'd1);
        req_valid1 = 1'b1; req_addr1 = 32'h0000_0FFC;
        step();                                          // T+1
        check("l3_cen",   32'(cen1),   32'd1);
        check("l3_maddr", 32'(maddr1), 32'h3FF);
        req_valid1 = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            step();                                      // T+2..T+4
            check("l3_iv_wait", 32'(inst_valid1), 32'd0);
            check("l3_maddr_h", 32'(maddr1),      32'h3FF);
            check("l3_cen_low", 32'(cen1),        32'd0);
        end
        step();                                          // T+5
        check("l3_iv",   32'(inst_valid1), 32'd1);
        check("l3_inst", inst1,            32'h1234_5678);
        inst_ready1 = 1'b1;
        step();
        check("l3_hs_iv",    32'(inst_valid1), 32'd0);
        check("l3_hs_ready", 32'(req_ready1),  32'd1);

        // Reset while in WAIT drops the fetch
        req_valid1 = 1'b1; req_addr1 = 32'h0000_0010;
        step();                                          // T+1 READ
        check("rw_cen", 32'(cen1), 32'd1);
        req_valid1 = 1'b0;
        step();                                          // T+2 WAIT
        rst1 = 1'b1;
        step();
        check("rw_ready", 32'(req_ready1),  32'd1);
        check("rw_cen0",  32'(cen1),        32'd0);
        check("rw_maddr", 32'(maddr1),      32'd0);
        check("rw_inst",  inst1,            32'd0);
        check("rw_iv",    32'(inst_valid1), 32'd0);
        check("rw_halt",  32'(halted1),     32'd0);
        rst1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rw_iv_after", 32'(inst_valid1), 32'd0);
            check("rw_inst_aft", inst1,            32'd0);
        end

        // Fresh request after reset completes normally
        req_valid1 = 1'b1; req_addr1 = 32'h0000_0020;
        step();
        check("rf_cen",   32'(cen1),   32'd1);
        check("rf_maddr", 32'(maddr1), 32'd8);
        req_valid1 = 1'b0;
        step();
        step();
        step();
        check("rf_iv_t4", 32'(inst_valid1), 32'd0);
        step();
        check("rf_iv",   32'(inst_valid1), 32'd1);
        check("rf_inst", inst1,            32'hC0DE_0008);
        step();
        check("rf_done", 32'(inst_valid1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
